riscv_if_prefetch: RTL
======================

// Module: riscv_if_prefetch
// PURPOSE
//  Instruction-fetch front end between the core's IF port and a req/ack instruction memory bus.
//  Accepts next-PC from core, issues one bus read at a time, queues returned parcels with PC and
//  error flags in a small FIFO, presents them on the if_parcel* bus. Handles stall, flush and misalignment.
// PARAMETERS
//  XLEN         32     address/data width
//  PARCEL_SIZE  32     parcel width; if_parcel_valid has PARCEL_SIZE/16 bits
//  DEPTH        4      parcel queue entries (power of 2, >=2)
// PORTS
//  clk                  in   1              clock, rising edge
//  rstn                 in   1              asynchronous active-low reset
//  if_nxt_pc            in   XLEN           next fetch PC from core
//  if_stall_nxt_pc      out  1              1: if_nxt_pc not accepted this cycle
//  if_stall             in   1              core stalled; hold head parcel
//  if_flush             in   1              discard queue and in-flight fetch
//  if_parcel            out  PARCEL_SIZE    head parcel
//  if_parcel_pc         out  XLEN           PC of head parcel
//  if_parcel_valid      out  PARCEL_SIZE/16 all-ones when head valid, else 0
//  if_parcel_misaligned out  1              head entry misaligned (parcel = 0)
//  if_parcel_page_fault out  1              head entry bus error (parcel = 0)
//  imem_adr             out  XLEN           bus address, stable while imem_req
//  imem_req             out  1              bus request, held until ack/err
//  imem_ack             in   1              read data valid on imem_q
//  imem_err             in   1              bus error, terminates request
//  imem_q               in   PARCEL_SIZE    read data
// BEHAVIOUR
//  Reset: imem_req=0, imem_adr=0, queue empty, if_parcel_valid=0, flags 0, state IDLE.
//  Accept: PC taken when !if_stall_nxt_pc && !if_flush. if_stall_nxt_pc = (state!=IDLE) | (count+inflight>=DEPTH).
//  FSM: IDLE -> REQ on accept with pc[1:0]==0 (imem_adr<=pc, imem_req<=1 next cycle).
//       REQ: on ack push {imem_q,adr,0,0}; on err push {0,adr,0,1}; -> IDLE. ack&err same cycle = err.
//       REQ & if_flush (no ack/err) -> DISCARD, imem_req held (bus not aborted).
//       DISCARD: on ack or err drop data, imem_req<=0 -> IDLE. Accept blocked in DISCARD.
//  Misaligned accept (pc[1:0]!=0): no bus cycle; push {0,pc,1,0} next cycle, stays IDLE.
//  Pop: head consumed when valid && !if_stall && !if_flush. Simultaneous push/pop on full allowed; count unchanged.
//  Flush: queue emptied next cycle; ack/err arriving in same cycle as flush is dropped; flush wins over push.
//  Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits, never exceeds DEPTH (guaranteed by accept rule).
//  Latency: accept -> imem_req 1 cycle; ack -> if_parcel_valid 1 cycle (registered queue read).
//  Reset mid-transaction: request dropped immediately; late ack after reset ignored (state IDLE).
// CONFIGURATION
//  RV_IF_PREFETCH_BYPASS_EN defined: when queue empty and ack (no err, no flush) arrives, parcel/pc drive
//   outputs combinationally that cycle; if !if_stall it is consumed and not written to queue (0-cycle latency).
//  Not defined: all parcels pass through queue; ack-to-valid latency 1 cycle.
// STRUCTURE
//  riscv_if_prefetch_pkg: typedef struct packed {parcel,pc,misaligned,page_fault} ifq_entry_t;
//   enum {IDLE,REQ,DISCARD} ifq_state_t.
//  Sub-module riscv_ifq_fifo: parameterised DEPTH FIFO of ifq_entry_t with push/pop/clear, count, empty/full.
//  Top holds FSM, accept logic, bypass mux.
// TESTING
//  Sequential fetch 0x200,0x204,0x208, ack 1 cycle after req, data 0x13 -> three parcels PC 0x200.. in order, valid=2'b11.
//  if_stall=1 for 6 cycles with continuous fetch, DEPTH=4 -> if_stall_nxt_pc=1 once 4 entries held; no entry lost/duplicated.
//  Flush while REQ outstanding at 0x210, ack 3 cycles later -> data dropped, valid=0, next PC 0x400 fetched after ack.
//  imem_err on fetch 0x220 -> entry PC 0x220, page_fault=1, parcel=0; next fetch normal.
//  if_nxt_pc=0x202 -> no imem_req, misaligned=1 with PC 0x202 one cycle later.
//  Bypass build: empty queue, ack data 0x00000093 -> if_parcel_valid same cycle; non-bypass build -> next cycle.

Source files
------------

// File: rtl/riscv_if_prefetch_pkg.sv
// Shared types for the instruction prefetcher: queue entry layout and fetch FSM states.
// Entry widths follow the default 32-bit XLEN / parcel configuration.
package riscv_if_prefetch_pkg;

  localparam int IFQ_XLEN        = 32;
  localparam int IFQ_PARCEL_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } ifq_state_t;

  typedef struct packed {
    logic [IFQ_PARCEL_SIZE-1:0] parcel;
    logic [IFQ_XLEN-1:0]        pc;
    logic                       misaligned;
    logic                       page_fault;
  } ifq_entry_t;

endpackage

// File: rtl/riscv_ifq_fifo.sv
// Parcel queue: DEPTH-entry FIFO of ifq_entry_t, head readable the cycle after a push.
// No internal backpressure; the producer must never push into a full queue without a matching pop.
module riscv_ifq_fifo
  import riscv_if_prefetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  ifq_entry_t    push_dat,
  output ifq_entry_t    head,
  output logic [CW-1:0] cnt,
  output logic          empty,
  output logic          full
);

  ifq_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only observed once cnt says they were written.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_dat;
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/riscv_if_prefetch.sv
// IF front end: one outstanding imem read, parcels queued with PC/error flags; ack-to-valid 1 cycle,
// 0 cycles when RV_IF_PREFETCH_BYPASS_EN is defined. if_stall_nxt_pc holds the core off while busy or queue would fill.
module riscv_if_prefetch
  import riscv_if_prefetch_pkg::*;
#(
  parameter int XLEN        = IFQ_XLEN,
  parameter int PARCEL_SIZE = IFQ_PARCEL_SIZE,
  parameter int DEPTH       = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [XLEN-1:0]           if_nxt_pc,
  output logic                      if_stall_nxt_pc,
  input  logic                      if_stall,
  input  logic                      if_flush,
  output logic [PARCEL_SIZE-1:0]    if_parcel,
  output logic [XLEN-1:0]           if_parcel_pc,
  output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
  output logic                      if_parcel_misaligned,
  output logic                      if_parcel_page_fault,
  output logic [XLEN-1:0]           imem_adr,
  output logic                      imem_req,
  input  logic                      imem_ack,
  input  logic                      imem_err,
  input  logic [PARCEL_SIZE-1:0]    imem_q
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_t      state_q, state_d;
  logic [XLEN-1:0] adr_q;
  logic [CW-1:0]   q_cnt;
  logic            q_empty, q_full;
  ifq_entry_t      q_head, push_dat, rsp_entry, head;
  logic            push, pop, accept, rsp, pc_misaligned;
  logic            byp_vld, byp_take, head_vld;
  logic [CW:0]     occupancy;

  // An outstanding read reserves a slot so its parcel always has room on return.
  assign occupancy       = {1'b0, q_cnt} + {{CW{1'b0}}, (state_q == REQ)};
  assign if_stall_nxt_pc = (state_q != IDLE) | q_full | (occupancy >= (CW+1)'(DEPTH));
  assign accept          = ~if_stall_nxt_pc & ~if_flush;
  assign pc_misaligned   = |if_nxt_pc[1:0];
  assign rsp             = imem_ack | imem_err;

  // Error takes priority over a coincident ack.
  always_comb begin
    rsp_entry            = '0;
    rsp_entry.parcel     = imem_err ? '0 : imem_q;
    rsp_entry.pc         = adr_q;
    rsp_entry.page_fault = imem_err;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && !pc_misaligned) state_d = REQ;
      REQ:     if (rsp) state_d = IDLE;
               else if (if_flush) state_d = DISCARD;
      DISCARD: if (rsp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept && !pc_misaligned) adr_q <= if_nxt_pc;
    end
  end

  assign imem_req = (state_q != IDLE);
  assign imem_adr = adr_q;

`ifdef RV_IF_PREFETCH_BYPASS_EN
  assign byp_vld = q_empty & (state_q == REQ) & imem_ack & ~imem_err & ~if_flush;
`else
  assign byp_vld = 1'b0;
`endif
  assign byp_take = byp_vld & ~if_stall;

  // Misaligned PCs skip the bus and enter the queue directly; only possible in IDLE, so never collides with a response.
  always_comb begin
    push     = 1'b0;
    push_dat = rsp_entry;
    if (accept && pc_misaligned) begin
      push                = 1'b1;
      push_dat            = '0;
      push_dat.pc         = if_nxt_pc;
      push_dat.misaligned = 1'b1;
    end else if ((state_q == REQ) && rsp && !if_flush && !byp_take) begin
      push = 1'b1;
    end
  end

  assign pop = ~q_empty & ~if_stall & ~if_flush;

  riscv_ifq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .pop      (pop),
    .clear    (if_flush),
    .push_dat (push_dat),
    .head     (q_head),
    .cnt      (q_cnt),
    .empty    (q_empty),
    .full     (q_full)
  );

  assign head     = byp_vld ? rsp_entry : q_head;
  assign head_vld = ~q_empty | byp_vld;

  assign if_parcel            = head.parcel;
  assign if_parcel_pc         = head.pc;
  assign if_parcel_valid      = {(PARCEL_SIZE/16){head_vld}};
  assign if_parcel_misaligned = head.misaligned & head_vld;
  assign if_parcel_page_fault = head.page_fault & head_vld;

endmodule
